rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N-way, WIDTH-bit arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Selects one requesting channel per cycle, either round-robin or fixed-priority, and registers the winner into a single output stage (1-cycle latency).
- Used wherever several pipeline producers share one consumer in the multi-cycle/pipelined CPU, e.g. writeback-source or memory-request merging.

Parameters:
- WIDTH, 32, data bits per channel (>=1)
- N, 4, number of input channels (>=2; need not be a power of 2)
- SEL_W, $clog2(N), width of channel index; derived, never overridden

Ports:
- CLK  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- rr_mode  input  1  1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- in_valid  input  N  per-channel request
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N  one-hot or zero; channel i accepted when in_valid[i] && in_ready[i]
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered winning data
- out_src  output  SEL_W  index of channel that produced out_data
- out_ready  input  1  consumer accepts beat when out_valid && out_ready

Behaviour:
- Reset (async, any time, including mid-transfer): out_valid=0, out_data=0, out_src=0, rr pointer last=N-1 (channel 0 has first priority); any buffered beat is dropped.
- load_en = !out_valid || out_ready. in_ready is combinational: all zero when load_en=0 or no in_valid set; otherwise exactly the granted channel's bit is 1.
- Grant, round-robin (rr_mode=1): first i with in_valid[i]=1, searching last+1, last+2, ... mod N; wrap from N-1 to 0 also for non-power-of-2 N.
- Grant, fixed priority (rr_mode=0): lowest index with in_valid=1; pointer not consulted.
- Pointer update: last <= grant only on an accepted transfer, in either mode. No transfer leaves the pointer unchanged. A rr_mode change takes effect the same cycle.
- On accepted transfer at edge k: out_valid=1, out_data=in_data[g], out_src=g from cycle k+1 (latency 1).
- Back-pressure: while out_valid && !out_ready, out_data/out_src are held stable and no input is accepted.
- Simultaneous drain and load (out_valid && out_ready && grant exists): the register is replaced with the new beat, so out_valid stays 1 and throughput is 1 beat/cycle.
- Drain without new grant: out_valid <= 0; out_data/out_src keep their last values (don't-care while invalid).
- Single requester: granted every cycle regardless of pointer position.
- in_valid dropping without a handshake is permitted: no state change, no grant.

Optional Feature:
- Macro: RR_ARB_MUX_STATS_EN.
- Defined: extra output grant_cnt [N*16], with one 16-bit counter per channel at [i*16 +: 16]. Each counter increments on every accepted transfer from that channel, saturates at 16'hFFFF, and is cleared to 0 by Reset.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package rr_arb_mux_pkg: constant STAT_CNT_W=16, constant STAT_CNT_MAX=16'hFFFF, helper function next_idx(idx,N) implementing mod-N increment.
- One sub-module, rr_arbiter: purely combinational. Inputs are request vector, pointer and mode; outputs are one-hot grant and encoded grant index. The pointer register and output stage stay in rr_arb_mux.

Test Plan:
- Reset then idle: Reset=1 mid-beat (out_valid=1) -> out_valid=0, out_src=0 immediately, before any clock edge; in_ready=0 with no requests.
- Round-robin fairness: N=4, rr_mode=1, all in_valid=1, out_ready=1, in_data[i]=32'hA0+i -> out_src sequence 0,1,2,3,0,1 with matching out_data, one beat per cycle.
- Fixed priority: rr_mode=0, in_valid=4'b1010 held -> every beat out_src=1, data 32'hA1; channel 3 never sees in_ready=1.
- Back-pressure: out_valid=1 with out_ready=0 for 3 cycles -> out_data/out_src unchanged, in_ready=0; out_ready=1 -> next beat loads the same cycle.
- Non-power-of-2 wrap: N=3, last=2, in_valid=3'b101 -> grant 0, then grant 2, then grant 0.
- Stats (RR_ARB_MUX_STATS_EN): 70000 grants to channel 1 -> grant_cnt[1]=16'hFFFF, others 0; Reset -> all 0.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the rr_arb_mux arbitrating multiplexer.
package rr_arb_mux_pkg;

    localparam int unsigned STAT_CNT_W   = 16;
    localparam logic [15:0] STAT_CNT_MAX = 16'hFFFF;

    // Mod-n increment; wraps explicitly so non-power-of-2 channel counts work.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin starting after the pointer, or fixed lowest-index priority.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    input  logic             rr_mode,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        if (rr_mode) begin
            idx = SEL_W'(next_idx(32'(last), N));
            for (int k = 0; k < int'(N); k++) begin
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant_idx  = idx;
                    grant[idx] = 1'b1;
                end
                idx = SEL_W'(next_idx(32'(idx), N));
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (!found && req[i]) begin
                    found     = 1'b1;
                    grant_idx = SEL_W'(i);
                    grant[i]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-way arbitrating mux with valid/ready handshakes and a single registered output stage.
// Optional per-channel grant counters when RR_ARB_MUX_STATS_EN is defined.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               rr_mode,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    input  logic               out_ready
`ifdef RR_ARB_MUX_STATS_EN
    ,
    output logic [N*STAT_CNT_W-1:0] grant_cnt
`endif
);

    logic [SEL_W-1:0] last;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             fire;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .req       (in_valid),
        .last      (last),
        .rr_mode   (rr_mode),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign load_en  = !out_valid || out_ready;
    assign fire     = load_en && (|in_valid);
    assign in_ready = load_en ? grant : '0;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            last      <= SEL_W'(N - 1);
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= in_data[32'(grant_idx) * WIDTH +: WIDTH];
            out_src   <= grant_idx;
            last      <= grant_idx;
        end else if (out_ready) begin
            // Drained with nothing to replace it; data/src keep stale values.
            out_valid <= 1'b0;
        end
    end

`ifdef RR_ARB_MUX_STATS_EN
    for (genvar i = 0; i < int'(N); i++) begin : g_stat
        logic [STAT_CNT_W-1:0] cnt;
        always_ff @(posedge CLK or posedge Reset) begin
            if (Reset) begin
                cnt <= '0;
            end else if (fire && grant[i] && cnt != STAT_CNT_MAX) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grant_cnt[i*STAT_CNT_W +: STAT_CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: N=4 main instance plus an N=3 instance for wrap checks.
module tb_rr_arb_mux;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rr_mode;
    logic [3:0]  in_valid;
    logic [127:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    logic [2:0]  c3_in_valid;
    logic [95:0] c3_in_data;
    logic [2:0]  c3_in_ready;
    logic        c3_out_valid;
    logic [31:0] c3_out_data;
    logic [1:0]  c3_out_src;
    logic        c3_out_ready;

`ifdef RR_ARB_MUX_STATS_EN
    logic [63:0] grant_cnt;
    logic [47:0] c3_grant_cnt;
`endif

    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b1;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(32), .N(4)) dut (
        .CLK       (clk),
        .Reset     (rst),
        .rr_mode   (rr_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef RR_ARB_MUX_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    rr_arb_mux #(.WIDTH(32), .N(3)) dut3 (
        .CLK       (clk),
        .Reset     (rst),
        .rr_mode   (rr_mode),
        .in_valid  (c3_in_valid),
        .in_data   (c3_in_data),
        .in_ready  (c3_in_ready),
        .out_valid (c3_out_valid),
        .out_data  (c3_out_data),
        .out_src   (c3_out_src),
        .out_ready (c3_out_ready)
`ifdef RR_ARB_MUX_STATS_EN
        ,
        .grant_cnt (c3_grant_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int src, input int n);
        beat_t b;
        b.src  = 2'(src);
        b.data = 32'hA0 + 32'(src);
        for (int k = 0; k < n; k++) exp_q.push_back(b);
    endtask

    // Monitor: every beat the consumer takes must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && mon_en && out_valid && out_ready) begin
            beat_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got src=%0d data=%h expected none", out_src, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_src !== e.src || out_data !== e.data) begin
                    errors++;
                    $display("FAIL beat: got src=%0d data=%h expected src=%0d data=%h",
                             out_src, out_data, e.src, e.data);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] c3_exp [3];
        rst          = 1'b1;
        rr_mode      = 1'b1;
        in_valid     = '0;
        in_data      = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        out_ready    = 1'b0;
        c3_in_valid  = '0;
        c3_in_data   = {32'hB2, 32'hB1, 32'hB0};
        c3_out_ready = 1'b0;
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_src", 32'(out_src), 32'd0);
        chk("reset_in_ready_idle", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Round-robin, all requesting: 0,1,2,3,0,1 at one beat per cycle.
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int s = 0; s < 6; s++) push(s % 4, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rr_drained_valid", 32'(out_valid), 32'd0);
        chk("rr_queue_empty", 32'(exp_q.size()), 32'd0);

        // Fixed priority: channel 1 always beats channel 3.
        @(posedge clk);
        #1;
        rr_mode  = 1'b0;
        in_valid = 4'b1010;
        push(1, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fp_in_ready", 32'(in_ready), 32'(4'b0010));
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Single requester in round-robin mode, pointer 1: granted every cycle.
        @(posedge clk);
        #1;
        rr_mode  = 1'b1;
        in_valid = 4'b0100;
        push(2, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("single_in_ready", 32'(in_ready), 32'(4'b0100));
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("single_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-pressure: pointer 2, so channel 3 loads first and is held for 3 cycles.
        @(posedge clk);
        #1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        push(3, 1);
        push(0, 1);
        @(negedge clk);
        chk("bp_first_grant", 32'(in_ready), 32'(4'b1000));
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_src", 32'(out_src), 32'd3);
            chk("bp_hold_data", out_data, 32'hA3);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 32'(in_ready), 32'(4'b0001));
        @(posedge clk);
        #1;
        in_valid = '0;
        @(negedge clk);
        chk("bp_reload_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a beat is held; pointer returns to N-1.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        @(posedge clk);
        #1;
        in_valid = '0;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_src", 32'(out_src), 32'd0);
        chk("async_reset_data", out_data, 32'd0);
        chk("async_reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        push(0, 1);
        @(negedge clk);
        chk("post_reset_grant", 32'(in_ready), 32'(4'b0001));
        @(posedge clk);
        #1;
        in_valid = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_reset_queue_empty", 32'(exp_q.size()), 32'd0);

        // N=3 wrap: pointer 2, requests 101 -> grants 0, 2, 0.
        @(posedge clk);
        #1;
        c3_exp[0] = 3'd0;
        c3_exp[1] = 3'd2;
        c3_exp[2] = 3'd0;
        c3_in_valid  = 3'b101;
        c3_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("n3_in_ready", 32'(c3_in_ready), 32'(3'b001 << c3_exp[k]));
            @(posedge clk);
            #1;
            chk("n3_out_src", 32'(c3_out_src), 32'(c3_exp[k]));
            chk("n3_out_data", c3_out_data, 32'hB0 + 32'(c3_exp[k]));
        end
        c3_in_valid = '0;

`ifdef RR_ARB_MUX_STATS_EN
        rst = 1'b1;
        #1 rst = 1'b0;
        mon_en    = 1'b0;
        rr_mode   = 1'b1;
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        in_valid = '0;
        chk("stat_cnt0", 32'(grant_cnt[15:0]), 32'd0);
        chk("stat_cnt1_sat", 32'(grant_cnt[31:16]), 32'h0000FFFF);
        chk("stat_cnt2", 32'(grant_cnt[47:32]), 32'd0);
        chk("stat_cnt3", 32'(grant_cnt[63:48]), 32'd0);
        rst = 1'b1;
        #1;
        chk("stat_cnt1_reset", 32'(grant_cnt[31:16]), 32'd0);
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
